// File: rtl/pcie_gen3_scrambler.sv
// pcie_gen3_scrambler: 128b/130b per-lane TX scrambler with Gen3 block rules.
// The LFSR is a Galois register advanced DATA_W bits per word through an unrolled loop.
module pcie_gen3_scrambler #(
    parameter int DATA_W = 32,
    parameter int LANE   = 0
) (
    input  logic              pclk,
    input  logic              reset_n,
    input  logic              in_valid,
    input  logic              in_blk_start,
    input  logic [1:0]        in_sync_hdr,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    output logic              out_blk_start,
    output logic [1:0]        out_sync_hdr,
    output logic [DATA_W-1:0] out_data,
    output logic [22:0]       lfsr_state
);
    localparam int WORDS = 128 / DATA_W;
    localparam int CW = $clog2(WORDS);
    localparam logic [22:0] TAPS = 23'h210125;

    function automatic logic [22:0] seed_of(input int l);
        logic [22:0] s;
        s = 23'h1DBFBC;
        case (l % 8)
            1: s = 23'h0607BB;
            2: s = 23'h1EC760;
            3: s = 23'h18C0DB;
            4: s = 23'h010F12;
            5: s = 23'h19CFC9;
            6: s = 23'h0277CE;
            7: s = 23'h1BB807;
            default: s = 23'h1DBFBC;
        endcase
        return s;
    endfunction

    localparam logic [22:0] SEED = seed_of(LANE);

    typedef enum logic [2:0] {IDLE, DATA, EIEOS, SKP, OS_OTHER} kind_t;

    kind_t state, state_nx, kind_dec, kind_cur;
    logic [CW-1:0] wcnt, wcnt_nx;
    logic [22:0] lfsr_adv, lfsr_nx;
    logic [DATA_W-1:0] ks, mask;
    logic last, adv, hdr_bad, err_hdr;

    always_comb begin : keystream
        logic [22:0] s;
        s = lfsr_state;
        ks = '0;
        for (int k = 0; k < DATA_W; k++) begin
            ks[k] = s[22];
            s = {s[21:0], 1'b0} ^ (s[22] ? TAPS : 23'h0);
        end
        lfsr_adv = s;
    end

    always_comb begin
        hdr_bad = (in_sync_hdr == 2'b00) || (in_sync_hdr == 2'b11);
        kind_dec = (in_sync_hdr != 2'b01) ? DATA :
                   (in_data[7:0] == 8'h00) ? EIEOS :
                   (in_data[7:0] == 8'hAA) ? SKP : OS_OTHER;
        kind_cur = in_blk_start ? kind_dec : state;
        last = !in_blk_start && (wcnt == CW'(WORDS - 1));
        adv = (kind_cur == DATA) || (kind_cur == OS_OTHER);
        mask = adv ? ks : '0;
        // TS-style symbol 0 goes out in clear but still burns its keystream bits
        mask[7:0] = (kind_cur == OS_OTHER && in_blk_start) ? 8'h00 : mask[7:0];
        lfsr_nx = (kind_cur == EIEOS && last) ? SEED : adv ? lfsr_adv : lfsr_state;
        state_nx = in_blk_start ? kind_dec : last ? IDLE : state;
        wcnt_nx = in_blk_start ? CW'(1) : (last || state == IDLE) ? '0 : wcnt + CW'(1);
    end

    always_ff @(posedge pclk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid     <= 1'b0;
            out_blk_start <= 1'b0;
            out_sync_hdr  <= 2'b00;
            out_data      <= '0;
            lfsr_state    <= SEED;
            state         <= IDLE;
            wcnt          <= '0;
            err_hdr       <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                out_blk_start <= in_blk_start;
                out_sync_hdr  <= in_sync_hdr;
                out_data      <= in_data ^ mask;
                lfsr_state    <= lfsr_nx;
                state         <= state_nx;
                wcnt          <= wcnt_nx;
                err_hdr       <= err_hdr | (in_blk_start && hdr_bad);
            end
        end
    end
endmodule
